// File: rtl/javk_memctl.sv
// javk_memctl: JAVK core to async 8-bit SRAM bridge.
// Posted one-entry write buffer, read forwarding, wait-state timing.
module javk_memctl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              wbuf_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACC
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] wb_addr;
    logic [7:0]        wb_data;
    logic              wb_valid;

    logic take;
    logic hit;
    logic wr_go;
    logic rd_go;

    // The ack cycle is never taken as a fresh request.
    assign take  = cpu_req && !cpu_ack;
    assign hit   = take && !cpu_rw && wb_valid && (cpu_addr == wb_addr);
    assign wr_go = take && cpu_rw && (state == IDLE) && !wb_valid;
    assign rd_go = take && !cpu_rw && (state == IDLE) && !wb_valid;

    assign wbuf_busy = wb_valid;

    // Request acceptance, buffer forwarding and SRAM strobe sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            wb_addr     <= '0;
            wb_data     <= 8'h00;
            wb_valid    <= 1'b0;
            cpu_rdata   <= 8'h00;
            cpu_ack     <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 8'h00;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            if (hit) begin
                cpu_rdata <= wb_data;
                cpu_ack   <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (wr_go) begin
                        wb_addr     <= cpu_addr;
                        wb_data     <= cpu_wdata;
                        wb_valid    <= 1'b1;
                        cpu_ack     <= 1'b1;
                        sram_addr   <= cpu_addr;
                        sram_dq_out <= cpu_wdata;
                        sram_dq_oe  <= 1'b1;
                        sram_ce_n   <= 1'b0;
                        sram_we_n   <= 1'b1;
                        state       <= WR_SETUP;
                    end else if (rd_go) begin
                        sram_addr  <= cpu_addr;
                        sram_dq_oe <= 1'b0;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b0;
                        cnt        <= WAIT_LD;
                        state      <= RD_ACC;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt       <= WAIT_LD;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    wb_valid   <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    state      <= IDLE;
                end
                RD_ACC: begin
                    if (cnt == 4'd0) begin
                        cpu_rdata <= sram_dq_in;
                        cpu_ack   <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_javk_memctl.sv
// tb_javk_memctl: directed bench for javk_memctl.
// Two builds: WAIT_CYCLES=2 (u0) and WAIT_CYCLES=0 (u1).
module tb_javk_memctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, rw;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic [7:0]  rdata0, rdata1, dqo0, dqo1, dqi0, dqi1;
    logic [15:0] sa0, sa1;
    logic        ack0, ack1, busy0, busy1, dqoe0, dqoe1;
    logic        ce0, ce1, oe0, oe1, we0, we1;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];

    int checks = 0;
    int errors = 0;
    int oe_lo0 = 0;
    int oe_lo1 = 0;
    int we_lo0 = 0;
    logic pack0 = 1'b0;
    logic pack1 = 1'b0;

    javk_memctl #(.WAIT_CYCLES(2), .ADDR_W(16)) u0 (
        .clk(clk), .rst(rst),
        .cpu_req(req0), .cpu_rw(rw), .cpu_addr(addr), .cpu_wdata(wdata),
        .cpu_rdata(rdata0), .cpu_ack(ack0), .wbuf_busy(busy0),
        .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_oe(dqoe0),
        .sram_dq_in(dqi0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
    );

    javk_memctl #(.WAIT_CYCLES(0), .ADDR_W(16)) u1 (
        .clk(clk), .rst(rst),
        .cpu_req(req1), .cpu_rw(rw), .cpu_addr(addr), .cpu_wdata(wdata),
        .cpu_rdata(rdata1), .cpu_ack(ack1), .wbuf_busy(busy1),
        .sram_addr(sa1), .sram_dq_out(dqo1), .sram_dq_oe(dqoe1),
        .sram_dq_in(dqi1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
    );

    // Async SRAM models: read is combinational, write commits at the end
    // of a complete we_n pulse (an aborted pulse under reset is lost).
    assign dqi0 = mem0[sa0];
    assign dqi1 = mem1[sa1];

    always @(posedge we0) if (rst && !ce0) mem0[sa0] = dqo0;
    always @(posedge we1) if (rst && !ce1) mem1[sa1] = dqo1;

    // Strobe counters and bus invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!oe0) oe_lo0++;
        if (!oe1) oe_lo1++;
        if (!we0) we_lo0++;
        if (!oe0 && !we0) begin
            errors++;
            $display("FAIL strobe_overlap0: oe_n=%b we_n=%b", oe0, we0);
        end
        if (!oe1 && !we1) begin
            errors++;
            $display("FAIL strobe_overlap1: oe_n=%b we_n=%b", oe1, we1);
        end
        if (!oe0 && dqoe0) begin
            errors++;
            $display("FAIL dq_contention0: oe_n=%b dq_oe=%b", oe0, dqoe0);
        end
        if (!oe1 && dqoe1) begin
            errors++;
            $display("FAIL dq_contention1: oe_n=%b dq_oe=%b", oe1, dqoe1);
        end
        if (ack0 && pack0) begin
            errors++;
            $display("FAIL ack_pulse0: ack high two cycles");
        end
        if (ack1 && pack1) begin
            errors++;
            $display("FAIL ack_pulse1: ack high two cycles");
        end
        pack0 = ack0;
        pack1 = ack1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One request on instance sel; latency counts edges from request
    // assertion to the edge that raises ack.
    task automatic apply(input bit sel, input bit w, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd,
                         input int exp_cyc, input int exp_oe,
                         input int gap, input string name);
        int cyc;
        int o0;
        logic got;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        rw    = w;
        addr  = a;
        wdata = d;
        if (sel) req1 = 1'b1;
        else     req0 = 1'b1;
        o0  = sel ? oe_lo1 : oe_lo0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            got = sel ? ack1 : ack0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk({name, "_ack"}, 32'(got), 32'd1);
        chk({name, "_lat"}, cyc, exp_cyc);
        if (!w) chk({name, "_rdata"}, sel ? rdata1 : rdata0, exp_rd);
        chk({name, "_oe_cycles"}, (sel ? oe_lo1 : oe_lo0) - o0, exp_oe);
    endtask

    typedef struct {
        bit          sel;
        bit          w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rd;
        int          cyc;
        int          oe;
        int          gap;
    } vec_t;

    vec_t tv [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[16'h0050] = 8'h44;
        mem0[16'h0200] = 8'h77;
        mem0[16'h0300] = 8'h5A;
        mem1[16'hFFFF] = 8'hE7;
        mem1[16'h0000] = 8'h12;

        // sel w  addr      data   rdata  cyc oe gap
        tv[0]  = '{0, 1, 16'h0100, 8'h3C, 8'h00, 1, 0, 10};
        tv[1]  = '{0, 0, 16'h0100, 8'h00, 8'h3C, 2, 0, 0};
        tv[2]  = '{0, 1, 16'h0100, 8'h55, 8'h00, 1, 0, 10};
        tv[3]  = '{0, 0, 16'h0200, 8'h00, 8'h77, 9, 3, 0};
        tv[4]  = '{0, 1, 16'h0001, 8'h11, 8'h00, 1, 0, 10};
        tv[5]  = '{0, 1, 16'h0002, 8'h22, 8'h00, 6, 0, 0};
        tv[6]  = '{0, 0, 16'h0001, 8'h00, 8'h11, 9, 3, 0};
        tv[7]  = '{0, 0, 16'h0002, 8'h00, 8'h22, 4, 3, 10};
        tv[8]  = '{0, 0, 16'h0300, 8'h00, 8'h5A, 4, 3, 2};
        tv[9]  = '{1, 0, 16'hFFFF, 8'h00, 8'hE7, 2, 1, 2};
        tv[10] = '{1, 0, 16'h0000, 8'h00, 8'h12, 3, 1, 0};
        tv[11] = '{0, 0, 16'h0100, 8'h00, 8'h55, 4, 3, 10};

        rst   = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        rw    = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n", 32'(ce0), 32'd1);
        chk("rst_oe_n", 32'(oe0), 32'd1);
        chk("rst_we_n", 32'(we0), 32'd1);
        chk("rst_dq_oe", 32'(dqoe0), 32'd0);
        chk("rst_sram_addr", 32'(sa0), 32'd0);
        chk("rst_dq_out", 32'(dqo0), 32'd0);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_rdata", 32'(rdata0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst = 1'b1;

        // Reset in the middle of a write pulse drops the buffered write.
        apply(0, 1, 16'h0050, 8'h99, 8'h00, 1, 0, 2, "t1_wr");
        @(posedge clk);
        #1;
        chk("t1_we_low", 32'(we0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t1_rst_we_n", 32'(we0), 32'd1);
        chk("t1_rst_ce_n", 32'(ce0), 32'd1);
        chk("t1_rst_dq_oe", 32'(dqoe0), 32'd0);
        chk("t1_rst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(0, 0, 16'h0050, 8'h00, 8'h44, 4, 3, 2, "t1_rd");

        // Posted write: pulse width and drain length.
        w0 = we_lo0;
        apply(0, 1, 16'h1234, 8'hA5, 8'h00, 1, 0, 3, "t2_wr");
        chk("t2_busy_set", 32'(busy0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t2_busy_hold", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_busy_clr", 32'(busy0), 32'd0);
        chk("t2_we_cycles", we_lo0 - w0, 32'd3);
        chk("t2_sram_data", 32'(mem0[16'h1234]), 32'hA5);

        for (int i = 0; i < 12; i++) begin
            apply(tv[i].sel, tv[i].w, tv[i].a, tv[i].d, tv[i].rd,
                  tv[i].cyc, tv[i].oe, tv[i].gap, $sformatf("v%0d", i));
        end

        repeat (8) @(posedge clk);
        #1;
        chk("t5_sram_0001", 32'(mem0[16'h0001]), 32'h11);
        chk("t5_sram_0002", 32'(mem0[16'h0002]), 32'h22);
        chk("end_busy", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/javk_memctl.md
Name: javk_memctl

Overview:
Memory controller directly downstream of the JAVK core's address/data/rw interface. It converts the core's per-access requests into timed strobes for an external asynchronous 8-bit SRAM (64 KiB).
- Writes are posted through a one-entry write buffer.
- Reads that hit the buffer are forwarded without an SRAM access.
- SRAM access time is set by a wait-state parameter.

Parameters:
WAIT_CYCLES, 2, extra cycles the SRAM strobe (oe_n or we_n) is held low beyond the first; legal range 0..15.
ADDR_W, 16, address width, matching the core's 16-bit address bus.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
cpu_req  input  1  access request; held high until cpu_ack is seen.
cpu_rw  input  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  input  ADDR_W  access address; stable while cpu_req is high.
cpu_wdata  input  8  write data; stable while cpu_req is high.
cpu_rdata  output  8  read data; valid in the cycle cpu_ack is high, held afterwards.
cpu_ack  output  1  one-cycle completion pulse.
wbuf_busy  output  1  write buffer holds an undrained write.
sram_addr  output  ADDR_W  SRAM address.
sram_dq_out  output  8  SRAM write data.
sram_dq_oe  output  1  drive enable for the SRAM data pins.
sram_dq_in  input  8  SRAM read data.
sram_ce_n  output  1  chip enable, active-low.
sram_oe_n  output  1  output enable, active-low.
sram_we_n  output  1  write enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous) applies at any time, including mid-access:
  - sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - cpu_ack=0, cpu_rdata=0, wbuf_busy=0, FSM=IDLE.
  - A pending buffered write is discarded.
- All outputs are registered.
- Handshake:
  - A request is sampled on a rising edge only when cpu_req=1 and cpu_ack=0. The request stays high during the ack cycle, and the ack cycle itself is never sampled as a new request.
  - cpu_ack is a one-cycle pulse and is never asserted two cycles in a row.
- Write buffer: one entry holding {addr, data, valid}; wbuf_busy = valid.
- Posted write, accepted when the buffer is empty and FSM=IDLE:
  - Edge 0 captures addr/data and sets valid.
  - cpu_ack is high in the cycle after edge 0 (latency 1).
  - The drain starts at the same edge.
- Write arriving while the buffer is full: stalls with no ack. It is accepted at the first sampling edge after the drain returns to IDLE. No write merging.
- Drain FSM: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE.
  - WR_SETUP (1 cycle): ce_n=0, we_n=1, addr/dq_out driven, dq_oe=1.
  - WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0; a 4-bit counter loads WAIT_CYCLES and counts down to 0.
  - WR_HOLD (1 cycle): we_n=1; ce_n, dq_oe and data still driven.
  - Leaving WR_HOLD clears valid and releases ce_n/dq_oe.
  - Total drain is WAIT_CYCLES+3 cycles.
- Read, buffer hit (valid=1 and cpu_addr equals the buffered address), in any FSM state:
  - cpu_rdata = buffered data, ack in the next cycle (latency 1).
  - The drain continues undisturbed.
- Read, buffer miss while valid=1: stalls until the drain completes and FSM=IDLE, then proceeds as a normal read.
- Normal read, FSM=IDLE with buffer empty: IDLE -> RD_ACC -> IDLE.
  - RD_ACC lasts WAIT_CYCLES+1 cycles with ce_n=0, oe_n=0, dq_oe=0, sram_addr=cpu_addr.
  - On the final RD_ACC edge, sram_dq_in is latched into cpu_rdata and ack is set.
  - Ack is high WAIT_CYCLES+2 cycles after the sampling edge; the strobes return high in the ack cycle.
- sram_oe_n and sram_we_n are never low simultaneously; sram_dq_oe is never 1 while sram_oe_n=0.
- Address compare is full ADDR_W width; the counter does not wrap because it saturates at 0 on exit.
- A write and a read are never accepted in the same cycle: one request port, one request at a time.

Test Plan:
1. Reset mid-WR_PULSE (WAIT_CYCLES=2) -> strobes high and wbuf_busy=0 immediately; a later read of that address returns the old SRAM content.
2. Write 0xA5 to 0x1234 -> ack 1 cycle later; we_n low exactly 3 cycles; SRAM model holds 0xA5 at 0x1234; wbuf_busy drops after 5 cycles.
3. Write 0x3C to 0x0100, then immediately read 0x0100 -> rdata=0x3C with ack 1 cycle after sampling, and no oe_n pulse.
4. Write to 0x0100, then read 0x0200 (SRAM holds 0x77) -> read stalls until drain ends, then oe_n low 3 cycles, rdata=0x77, ack 4 cycles after sampling.
5. Two back-to-back writes (0x11 at 0x0001, 0x22 at 0x0002) -> second ack only after the first drain completes; both bytes present in SRAM.
6. WAIT_CYCLES=0 build: read 0xFFFF -> oe_n low 1 cycle, ack 2 cycles after sampling; assertion that oe_n and we_n are never both low.
